// File: rtl/main_ram_ctrl.sv
// Clocked initiator for the asynchronous main RAM.
// Turns valid/ready requests into sequenced _cs/_oe/_w strobe cycles.
module main_ram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              _ram_cs,
  output logic              _ram_oe,
  output logic              _ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WSET,
    WPUL,
    WHLD,
    RACC,
    RDONE
  } state_t;

  localparam logic [7:0] WP_LD = 8'(WR_PULSE - 1);
  localparam logic [7:0] RW_LD = 8'(RD_WAIT - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] rdata_n;
  logic              cs_n, oe_n, w_n;
  logic              rdv_n, wd_n, rdy_n;

  // Outputs are registered copies of what the next state requires.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    rdata_n = rd_data;
    cs_n    = 1'b1;
    oe_n    = 1'b1;
    w_n     = 1'b1;
    rdv_n   = 1'b0;
    wd_n    = 1'b0;
    rdy_n   = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (req_valid) begin
          addr_n = req_addr;
          rdy_n  = 1'b0;
          cs_n   = 1'b0;
          if (req_write) begin
            wdata_n = req_wdata;
            state_n = WSET;
          end else begin
            oe_n    = 1'b0;
            cnt_n   = RW_LD;
            state_n = RACC;
          end
        end
      end
      WSET: begin
        cs_n    = 1'b0;
        w_n     = 1'b0;
        cnt_n   = WP_LD;
        state_n = WPUL;
      end
      WPUL: begin
        cs_n = 1'b0;
        if (cnt == 8'd0) begin
          wd_n    = 1'b1;
          state_n = WHLD;
        end else begin
          w_n   = 1'b0;
          cnt_n = cnt - 8'd1;
        end
      end
      WHLD: begin
        rdy_n   = 1'b1;
        state_n = IDLE;
      end
      RACC: begin
        if (cnt == 8'd0) begin
          rdata_n = ram_rdata;
          rdv_n   = 1'b1;
          state_n = RDONE;
        end else begin
          cs_n  = 1'b0;
          oe_n  = 1'b0;
          cnt_n = cnt - 8'd1;
        end
      end
      RDONE: begin
        rdy_n   = 1'b1;
        state_n = IDLE;
      end
      default: begin
        rdy_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_data   <= '0;
      _ram_cs   <= 1'b1;
      _ram_oe   <= 1'b1;
      _ram_w    <= 1'b1;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      rd_data   <= rdata_n;
      _ram_cs   <= cs_n;
      _ram_oe   <= oe_n;
      _ram_w    <= w_n;
      rd_valid  <= rdv_n;
      wr_done   <= wd_n;
      req_ready <= rdy_n;
    end
  end

endmodule

// File: tb/tb_main_ram_ctrl.sv
// Bench for main_ram_ctrl: two builds (2/2 and 1/4) against a
// transaction-level model plus an async RAM model.
module tb_main_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        reset[2];
  logic        req_valid[2];
  logic        req_ready[2];
  logic        req_write[2];
  logic [19:0] req_addr[2];
  logic [7:0]  req_wdata[2];
  logic        rd_valid[2];
  logic [7:0]  rd_data[2];
  logic        wr_done[2];

  logic [19:0] pool[4] = '{20'h00005, 20'h003FF, 20'hFFFFA, 20'h80000};

  task automatic chk(input int ln, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL lane%0d %s got=%0h exp=%0h", ln, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WP = (g == 0) ? 2 : 1;
    localparam int RW = (g == 0) ? 2 : 4;

    logic        cs_n, oe_n, w_n;
    logic [19:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  mem[16] = '{default: 8'h00};

    main_ram_ctrl #(
      .ADDR_W(20), .DATA_W(8), .WR_PULSE(WP), .RD_WAIT(RW)
    ) dut (
      .clk(clk),
      .reset(reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rd_valid(rd_valid[g]),
      .rd_data(rd_data[g]),
      .wr_done(wr_done[g]),
      ._ram_cs(cs_n),
      ._ram_oe(oe_n),
      ._ram_w(w_n),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
    );

    // async RAM: latches on falling _w while selected
    always @(negedge w_n)
      if (!cs_n) mem[ram_addr[3:0]] = ram_wdata;
    assign ram_rdata = mem[ram_addr[3:0]];

    // model: k = cycles since accept (0 = idle)
    int          k = 0;
    int          len = 0;
    bit          iw = 1'b0;
    logic [19:0] ea = '0;
    logic [7:0]  ew = '0;
    logic [7:0]  er = '0;
    logic [7:0]  rmem[16] = '{default: 8'h00};

    always @(posedge clk) begin
      if (reset[g]) begin
        k = 0; ea = '0; ew = '0; er = '0;
      end else if (k == 0) begin
        if (req_valid[g]) begin
          k  = 1;
          iw = req_write[g];
          ea = req_addr[g];
          if (iw) ew = req_wdata[g];
          len = iw ? WP + 2 : RW + 1;
        end
      end else if (k == len) begin
        k = 0;
      end else begin
        k++;
        if (iw && k == 2) rmem[ea[3:0]] = ew;
        if (!iw && k == len) er = rmem[ea[3:0]];
      end
    end

    logic        prev_cs = 1'b1;
    logic [19:0] prev_a = '0;
    logic [7:0]  prev_d = '0;

    initial begin
      @(posedge clk);
      forever begin
        @(negedge clk);
        chk(g, "ready", 32'(req_ready[g]), 32'(k == 0));
        chk(g, "cs", 32'(cs_n),
            32'(!(k >= 1 && k <= (iw ? len : RW))));
        chk(g, "w", 32'(w_n), 32'(!(iw && k >= 2 && k <= WP + 1)));
        chk(g, "oe", 32'(oe_n), 32'(!(!iw && k >= 1 && k <= RW)));
        chk(g, "wr_done", 32'(wr_done[g]), 32'(k != 0 && iw && k == len));
        chk(g, "rd_valid", 32'(rd_valid[g]), 32'(k != 0 && !iw && k == len));
        chk(g, "rd_data", 32'(rd_data[g]), 32'(er));
        chk(g, "ram_addr", 32'(ram_addr), 32'(ea));
        chk(g, "ram_wdata", 32'(ram_wdata), 32'(ew));
        chk(g, "w_oe_excl", 32'(!w_n && !oe_n), 32'(0));
        chk(g, "strobe_no_cs", 32'((!w_n || !oe_n) && cs_n), 32'(0));
        if (!prev_cs && !cs_n) begin
          chk(g, "addr_stable", 32'(ram_addr), 32'(prev_a));
          chk(g, "wdata_stable", 32'(ram_wdata), 32'(prev_d));
        end
        prev_cs = cs_n;
        prev_a  = ram_addr;
        prev_d  = ram_wdata;
      end
    end
  end

  // called at a negedge; returns at the negedge after the accept edge
  task automatic do_op(input int ln, input bit wr, input logic [19:0] a,
                       input logic [7:0] d, input bit keep);
    int t = 0;
    req_valid[ln] = 1'b1;
    req_write[ln] = wr;
    req_addr[ln]  = a;
    req_wdata[ln] = d;
    while (!req_ready[ln] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk(ln, "accept_timeout", 32'(t), 32'(0));
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid[ln] = 1'b0;
  endtask

  task automatic measure(input int ln, input string nm, input int exp);
    int n = 1;
    while (!(wr_done[ln] || rd_valid[ln]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(ln, nm, 32'(n), 32'(exp));
  endtask

  task automatic directed(input int ln, input int lw, input int lr);
    do_op(ln, 1'b1, 20'h00005, 8'hA5, 1'b0);
    measure(ln, "wr_lat", lw);
    do_op(ln, 1'b0, 20'h00005, 8'h00, 1'b0);
    measure(ln, "rd_lat", lr);
    chk(ln, "rd_a5", 32'(rd_data[ln]), 32'h0A5);
    repeat (2) @(negedge clk);
    chk(ln, "rd_hold", 32'(rd_data[ln]), 32'h0A5);
    do_op(ln, 1'b1, 20'h003FF, 8'h3C, 1'b1);
    chk(ln, "busy_not_ready", 32'(req_ready[ln]), 32'(0));
    do_op(ln, 1'b0, 20'h003FF, 8'h00, 1'b0);
    measure(ln, "b2b_rd_lat", lr);
    chk(ln, "rd_3c", 32'(rd_data[ln]), 32'h03C);
    // reset during the first write-pulse cycle
    do_op(ln, 1'b1, 20'h00005, 8'h5A, 1'b0);
    @(negedge clk);
    reset[ln] = 1'b1;
    @(negedge clk);
    reset[ln] = 1'b0;
    chk(ln, "rst_ready", 32'(req_ready[ln]), 32'(1));
    for (int i = 0; i < 4; i++) begin
      chk(ln, "rst_no_done", 32'(wr_done[ln]), 32'(0));
      @(negedge clk);
    end
    do_op(ln, 1'b0, 20'h00005, 8'h00, 1'b0);
    measure(ln, "rst_rd_lat", lr);
    chk(ln, "rd_committed", 32'(rd_data[ln]), 32'h05A);
  endtask

  task automatic random_ops(input int ln, input int n);
    bit keep;
    for (int i = 0; i < n; i++) begin
      keep = ($urandom_range(0, 3) == 0);
      do_op(ln, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
            8'($urandom), keep);
      if (!keep) begin
        if ($urandom_range(0, 9) == 0) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          reset[ln] = 1'b1;
          @(negedge clk);
          reset[ln] = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    req_valid[ln] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i]     = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i, "reset_ready", 32'(req_ready[i]), 32'(1));
      chk(i, "reset_rd_data", 32'(rd_data[i]), 32'(0));
      chk(i, "reset_pulses", 32'(wr_done[i] | rd_valid[i]), 32'(0));
      reset[i] = 1'b0;
    end
    @(negedge clk);
    directed(0, 4, 3);
    directed(1, 3, 5);
    random_ops(0, 80);
    random_ops(1, 80);
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
